// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared constants, RAM command type and eligibility helper for the BRAM port arbiter
package bram_arb_pkg;

    localparam int PORT_IF = 0;
    localparam int PORT_DM = 1;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] di;
    } ram_cmd_t;

    // A port may issue only when it has no unconsumed response left over.
    function automatic logic port_eligible(input logic req, input logic rvalid, input logic rready);
        return req && !(rvalid && !rready);
    endfunction

endpackage

// File: rtl/bram_resp_hold.sv
// rtl/bram_resp_hold.sv - per-port response channel: in-flight flag, hold register and rdata bypass mux
module bram_resp_hold
    import bram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    input  logic              rready,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              inflight_q, inflight_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    // RAM output is only ours for the cycle after the grant; park it if not taken then.
    always_comb begin
        inflight_d   = grant;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (inflight_q && !rready) begin
            hold_valid_d = 1'b1;
            hold_d       = ram_dout;
        end else if (hold_valid_q && rready) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            inflight_q   <= inflight_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign rvalid = !rst && (inflight_q || hold_valid_q);
    assign rdata  = hold_valid_q ? hold_q : ram_dout;

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one single-port block RAM between instruction fetch and data memory
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              if_rready,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_rready,

    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic             starve_hit;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    ram_cmd_t         cmd;

    assign elig[PORT_IF] = port_eligible(if_req, if_rvalid, if_rready);
    assign elig[PORT_DM] = port_eligible(dm_req, dm_rvalid, dm_rready);
    assign starve_hit    = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // DM normally wins; IF takes the slot once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (elig[PORT_DM] && !(elig[PORT_IF] && starve_hit)) begin
                grant[PORT_DM] = 1'b1;
            end else if (elig[PORT_IF]) begin
                grant[PORT_IF] = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!elig[PORT_IF] || grant[PORT_IF]) begin
            starve_cnt_d = '0;
        end else if (grant[PORT_DM] && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        cmd.en   = grant[PORT_IF] || grant[PORT_DM];
        cmd.we   = grant[PORT_DM] && dm_we;
        cmd.addr = grant[PORT_DM] ? dm_addr : if_addr;
        cmd.di   = dm_wdata;
    end

    assign ram_en   = cmd.en;
    assign ram_we   = cmd.we;
    assign ram_addr = cmd.addr;
    assign ram_di   = cmd.di;
    assign ram_rst  = rst;

    assign if_ready = grant[PORT_IF];
    assign dm_ready = grant[PORT_DM];

    bram_resp_hold u_if_resp (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant[PORT_IF]),
        .rready   (if_rready),
        .ram_dout (ram_dout),
        .rvalid   (if_rvalid),
        .rdata    (if_rdata)
    );

    bram_resp_hold u_dm_resp (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant[PORT_DM]),
        .rready   (dm_rready),
        .ram_dout (ram_dout),
        .rvalid   (dm_rvalid),
        .rdata    (dm_rdata)
    );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter with a read-first RAM model
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, if_rvalid, if_rready;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready, dm_rvalid, dm_rready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        ram_en, ram_we, ram_rst;
    logic [31:0] ram_addr, ram_di, ram_dout;

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rready(if_rready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_rready(dm_rready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'hC0DE_0000 | (i & 32'hFFFF);
    endfunction

    always @(posedge clk) begin
        if (ram_rst) begin
            ram_dout <= '0;
        end else if (ram_en) begin
            ram_dout <= mem[ram_addr[11:2]];
            if (ram_we) mem[ram_addr[11:2]] <= ram_di;
        end
    end

    // Scoreboard: expectations pushed from an independent memory image at grant, popped on handshake.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            if_q.delete();
            dm_q.delete();
        end else begin
            if (if_rvalid && if_rready) begin
                checks++;
                if (if_q.size() == 0) $display("FAIL sb_if_unexpected: got rdata %h, want no response", if_rdata);
                else begin
                    e = if_q.pop_front();
                    if (if_rdata !== e) $display("FAIL sb_if_rdata: got %h want %h", if_rdata, e);
                    else passes++;
                end
            end
            if (dm_rvalid && dm_rready) begin
                checks++;
                if (dm_q.size() == 0) $display("FAIL sb_dm_unexpected: got rdata %h, want no response", dm_rdata);
                else begin
                    e = dm_q.pop_front();
                    if (dm_rdata !== e) $display("FAIL sb_dm_rdata: got %h want %h", dm_rdata, e);
                    else passes++;
                end
            end
            if (if_ready) if_q.push_back(shadow[if_addr[11:2]]);
            if (dm_ready) begin
                dm_q.push_back(shadow[dm_addr[11:2]]);
                if (dm_we) shadow[dm_addr[11:2]] = dm_wdata;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h0; dm_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            checks++; if (if_ready !== 1'b0 || dm_ready !== 1'b0 || ram_en !== 1'b0)
                $display("FAIL reset_no_grant: got if_ready=%b dm_ready=%b ram_en=%b want 0 0 0", if_ready, dm_ready, ram_en);
            else passes++;
            checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || ram_rst !== 1'b1)
                $display("FAIL reset_outputs: got if_rvalid=%b dm_rvalid=%b ram_rst=%b want 0 0 1", if_rvalid, dm_rvalid, ram_rst);
            else passes++;
        end
        cyc();
        rst = 1'b0; if_rready = 1'b1; dm_rready = 1'b1; dm_we = 1'b0;
        @(negedge clk);
        checks++; if (dm_ready !== 1'b1 || if_ready !== 1'b0)
            $display("FAIL reset_first_grant: got dm_ready=%b if_ready=%b want 1 0", dm_ready, if_ready);
        else passes++;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b0 || ram_en !== 1'b0 || dm_ready !== 1'b0)
            $display("FAIL reset_midop: got dm_rvalid=%b ram_en=%b dm_ready=%b want 0 0 0", dm_rvalid, ram_en, dm_ready);
        else passes++;
        cyc();
        @(negedge clk);
        checks++; if (dut.starve_cnt_q !== 3'd0 || ram_en !== 1'b0)
            $display("FAIL reset_starve: got starve_cnt=%0d ram_en=%b want 0 0", dut.starve_cnt_q, ram_en);
        else passes++;
        cyc();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0)
            $display("FAIL reset_dropped: got dm_rvalid=%b if_rvalid=%b want 0 0", dm_rvalid, if_rvalid);
        else passes++;
    endtask

    task automatic test_if_stream();
        for (int k = 0; k < 3; k++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'(4 * k); if_rready = 1'b1;
            @(negedge clk);
            checks++; if (if_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'(4 * k))
                $display("FAIL if_stream_grant%0d: got ready=%b en=%b we=%b addr=%h want 1 1 0 %h",
                         k, if_ready, ram_en, ram_we, ram_addr, 32'(4 * k));
            else passes++;
            if (k > 0) begin
                checks++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(k - 1))
                    $display("FAIL if_stream_data%0d: got rvalid=%b rdata=%h want 1 %h", k, if_rvalid, if_rdata, init_word(k - 1));
                else passes++;
            end
        end
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(2) || ram_en !== 1'b0)
            $display("FAIL if_stream_last: got rvalid=%b rdata=%h en=%b want 1 %h 0", if_rvalid, if_rdata, ram_en, init_word(2));
        else passes++;
    endtask

    task automatic test_store_load();
        cyc();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_rready = 1'b1;
        @(negedge clk);
        checks++; if (dm_ready !== 1'b1 || ram_we !== 1'b1 || ram_di !== 32'hDEADBEEF)
            $display("FAIL store_grant: got ready=%b we=%b di=%h want 1 1 deadbeef", dm_ready, ram_we, ram_di);
        else passes++;
        cyc();
        dm_we = 1'b0;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== init_word(32'h40) || dm_ready !== 1'b1)
            $display("FAIL store_ack: got rvalid=%b rdata=%h ready=%b want 1 %h 1", dm_rvalid, dm_rdata, dm_ready, init_word(32'h40));
        else passes++;
        cyc();
        dm_req = 1'b0;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADBEEF)
            $display("FAIL load_after_store: got rvalid=%b rdata=%h want 1 deadbeef", dm_rvalid, dm_rdata);
        else passes++;
    endtask

    task automatic test_fairness();
        logic exp_if;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'h10; if_rready = 1'b1;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_rready = 1'b1;
            @(negedge clk);
            exp_if = (i % 5 == 4);
            checks++; if (if_ready !== exp_if || dm_ready !== !exp_if)
                $display("FAIL fair_cycle%0d: got if_ready=%b dm_ready=%b want %b %b", i, if_ready, dm_ready, exp_if, !exp_if);
            else passes++;
        end
        cyc();
        if_req = 1'b0; dm_req = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        cyc();
        if_req = 1'b1; if_addr = 32'h30; if_rready = 1'b0; dm_req = 1'b0; dm_rready = 1'b1;
        @(negedge clk);
        checks++; if (if_ready !== 1'b1)
            $display("FAIL bp_if_grant: got if_ready=%b want 1", if_ready);
        else passes++;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if_addr = 32'h34; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'(32'h40 + 4 * k);
            @(negedge clk);
            checks++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(12) || if_ready !== 1'b0 || dm_ready !== 1'b1)
                $display("FAIL bp_hold%0d: got rvalid=%b rdata=%h if_ready=%b dm_ready=%b want 1 %h 0 1",
                         k, if_rvalid, if_rdata, if_ready, dm_ready, init_word(12));
            else passes++;
        end
        cyc();
        dm_req = 1'b0; if_rready = 1'b1;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== init_word(12) || if_ready !== 1'b1)
            $display("FAIL bp_release: got rvalid=%b rdata=%h if_ready=%b want 1 %h 1", if_rvalid, if_rdata, if_ready, init_word(12));
        else passes++;
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_ready !== 1'b0)
            $display("FAIL bp_reissue_resp: got rvalid=%b if_ready=%b want 1 0", if_rvalid, if_ready);
        else passes++;
    endtask

    task automatic test_back_to_back();
        cyc();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60; dm_rready = 1'b0;
        @(negedge clk);
        checks++; if (dm_ready !== 1'b1)
            $display("FAIL b2b_first: got dm_ready=%b want 1", dm_ready);
        else passes++;
        cyc();
        dm_addr = 32'h64;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b1 || dm_ready !== 1'b0)
            $display("FAIL b2b_blocked: got rvalid=%b ready=%b want 1 0", dm_rvalid, dm_ready);
        else passes++;
        cyc();
        dm_rready = 1'b1;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b1 || dm_ready !== 1'b1 || ram_addr !== 32'h64)
            $display("FAIL b2b_reissue: got rvalid=%b ready=%b addr=%h want 1 1 00000064", dm_rvalid, dm_ready, ram_addr);
        else passes++;
        cyc();
        dm_req = 1'b0;
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== init_word(32'h19))
            $display("FAIL b2b_second_resp: got rvalid=%b rdata=%h want 1 %h", dm_rvalid, dm_rdata, init_word(32'h19));
        else passes++;
        cyc();
        @(negedge clk);
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0)
            $display("FAIL b2b_idle: got dm_rvalid=%b if_rvalid=%b want 0 0", dm_rvalid, if_rvalid);
        else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_rready = 1'b1;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_rready = 1'b1;
        test_reset();
        test_if_stream();
        test_store_load();
        test_fairness();
        test_backpressure();
        test_back_to_back();
        checks++;
        if (if_q.size() != 0 || dm_q.size() != 0)
            $display("FAIL sb_drained: got if_q=%0d dm_q=%0d outstanding want 0 0", if_q.size(), dm_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
